// File: rtl/sample_fetch_pkg.sv
// Shared types and defaults for the sample SDRAM read scheduler.
package sample_fetch_pkg;

  localparam int unsigned NUM_CH_DEF  = 4;
  localparam int unsigned ADDR_W_DEF  = 25;
  localparam int unsigned TIMEOUT_DEF = 63;
  localparam int unsigned CNT_W       = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Clears the byte-select bit so every fetch is a 16-bit word read.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/sample_fetch_arb_rr.sv
// Combinational round-robin picker: first requester strictly after last_i, cyclic.
module rr_arbiter #(
  parameter int unsigned NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req_i,
  input  logic [$clog2(NUM_CH)-1:0] last_i,
  output logic [NUM_CH-1:0]         gnt_o,
  output logic [$clog2(NUM_CH)-1:0] idx_o
);
  localparam int unsigned IDX_W = $clog2(NUM_CH);

  // Scan farthest-to-nearest so the nearest requester after last_i overwrites the rest.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int unsigned k = NUM_CH; k >= 1; k--) begin
      if (|(req_i & (NUM_CH'(1) << ((32'(last_i) + k) % NUM_CH)))) begin
        gnt_o = NUM_CH'(1) << ((32'(last_i) + k) % NUM_CH);
        idx_o = IDX_W'((32'(last_i) + k) % NUM_CH);
      end
    end
  end

endmodule

// File: rtl/sample_fetch_arb.sv
// Round-robin read scheduler for the shared sample SDRAM port; yields the port to downloads.
// Optional per-voice one-word read cache is enabled by defining SAMPLE_FETCH_CACHE_EN.
module sample_fetch_arb
  import sample_fetch_pkg::*;
#(
  parameter int unsigned NUM_CH  = NUM_CH_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dl_active,
  input  logic                     dl_wr,
  input  logic [ADDR_W-1:0]        dl_addr,
  input  logic [7:0]               dl_data,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  output logic [NUM_CH-1:0]        ch_valid,
  output logic [15:0]              ch_data,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_rd,
  output logic                     mem_we,
  output logic [7:0]               mem_din,
  input  logic [15:0]              mem_dout,
  input  logic                     mem_ack,
  output logic                     timeout_err
);
  localparam int unsigned      IDX_W    = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rd_q, rd_d;
  logic [NUM_CH-1:0]   valid_q, valid_d;
  logic [15:0]         data_q, data_d;
  logic                terr_q, terr_d;

  logic [NUM_CH-1:0]   gnt;
  logic [IDX_W-1:0]    gnt_idx;
  logic [ADDR_W-1:0]   sel_addr;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req_i  (ch_req),
    .last_i (last_q),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx)
  );

  always_comb begin
    sel_addr = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) sel_addr = ch_addr[i*ADDR_W +: ADDR_W];
    end
  end

`ifdef SAMPLE_FETCH_CACHE_EN
  logic [ADDR_W-1:0] tag_q  [NUM_CH];
  logic [15:0]       cdat_q [NUM_CH];
  logic [NUM_CH-1:0] cval_q;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] hit_gnt;
  logic [IDX_W-1:0]  hit_idx;
  logic              fill_ack;
  logic              fill_to;

  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      hit[i] = ch_req[i] & cval_q[i] &
               (tag_q[i] == ADDR_W'(word_align(32'(ch_addr[i*ADDR_W +: ADDR_W]))));
    end
  end

  rr_arbiter #(.NUM_CH(NUM_CH)) u_hit_arb (
    .req_i  (hit),
    .last_i (last_q),
    .gnt_o  (hit_gnt),
    .idx_o  (hit_idx)
  );

  assign fill_ack = (state_q == ST_WAIT) && !dl_active && mem_ack;
  assign fill_to  = (state_q == ST_WAIT) && !dl_active && !mem_ack && (cnt_q == CNT_LAST);

  // A timed-out fill leaves the entry invalid; any download byte flushes every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cval_q <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        tag_q[i]  <= '0;
        cdat_q[i] <= '0;
      end
    end else if (dl_active && dl_wr) begin
      cval_q <= '0;
    end else if (fill_ack) begin
      tag_q[idx_q]  <= addr_q;
      cdat_q[idx_q] <= mem_dout;
      cval_q[idx_q] <= 1'b1;
    end else if (fill_to) begin
      cval_q[idx_q] <= 1'b0;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    rd_d    = 1'b0;
    valid_d = '0;
    data_d  = data_q;
    terr_d  = terr_q;
    case (state_q)
      ST_IDLE: begin
        if (!dl_active) begin
`ifdef SAMPLE_FETCH_CACHE_EN
          if (|hit_gnt) begin
            idx_d   = hit_idx;
            last_d  = hit_idx;
            data_d  = cdat_q[hit_idx];
            valid_d = hit_gnt;
            state_d = ST_DONE;
          end else
`endif
          if (|gnt) begin
            idx_d   = gnt_idx;
            addr_d  = ADDR_W'(word_align(32'(sel_addr)));
            rd_d    = 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (dl_active) begin
          state_d = ST_IDLE;
        end else begin
          last_d  = idx_q;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dl_active) begin
          // Rewind the pointer so the aborted voice is first in line again.
          last_d  = (idx_q == '0) ? IDX_W'(NUM_CH - 1) : idx_q - IDX_W'(1);
          state_d = ST_IDLE;
        end else if (mem_ack) begin
          data_d  = mem_dout;
          valid_d = NUM_CH'(1) << idx_q;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = '0;
          terr_d  = 1'b1;
          valid_d = NUM_CH'(1) << idx_q;
          state_d = ST_DONE;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= IDX_W'(NUM_CH - 1);
      idx_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      valid_q <= '0;
      data_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      terr_q  <= terr_d;
    end
  end

  // Download path owns the port outright while active.
  assign mem_rd      = rd_q & ~dl_active;
  assign mem_we      = dl_active & dl_wr;
  assign mem_din     = dl_active ? dl_data : 8'h00;
  assign mem_addr    = dl_active ? dl_addr : addr_q;
  assign ch_valid    = valid_q;
  assign ch_data     = data_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_sample_fetch_arb.sv
// Scoreboard bench for sample_fetch_arb: randomized voice traffic against a round-robin reference model.
module tb_sample_fetch_arb;
  localparam int unsigned NCH = 4;
  localparam int unsigned AW  = 25;
  localparam int unsigned TO  = 63;

  typedef struct {
    int          v;
    logic [15:0] d;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              dl_active, dl_wr;
  logic [AW-1:0]     dl_addr;
  logic [7:0]        dl_data;
  logic [NCH-1:0]    ch_req;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH-1:0]    ch_valid;
  logic [15:0]       ch_data;
  logic [AW-1:0]     mem_addr;
  logic              mem_rd, mem_we;
  logic [7:0]        mem_din;
  logic [15:0]       mem_dout;
  logic              mem_ack;
  logic              timeout_err;

  sample_fetch_arb #(.NUM_CH(NCH), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .ch_req(ch_req), .ch_addr(ch_addr), .ch_valid(ch_valid), .ch_data(ch_data),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_we(mem_we), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_ack(mem_ack), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t          expq[$];
  logic [AW-1:0] vq[NCH][$];
  int            want[NCH];
  int            m_last = NCH - 1;
  bit            use_force = 1'b0;
  logic [AW-1:0] force_addr = '0;
  bit            expect_none = 1'b0;
  bit            withhold = 1'b0;
  bit            stray_ack = 1'b0;
  int            lat_min = 1, lat_max = 1;
  int            rd_cnt = 0, valid_cnt = 0, last_valid_cyc = 0, n0 = 0;
  logic [AW-1:0] last_rd_addr = '0;
  bit            prev_rd = 1'b0;
  exp_t          mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // SDRAM contents: an address hash, with one fixed word for the directed read.
  function automatic logic [15:0] memword(input logic [AW-1:0] a);
    if (a == AW'(32'h100)) return 16'hBEEF;
    return 16'(a[15:0] * 16'd40503) ^ 16'(a[AW-1:9]);
  endfunction

  // Voice driver: holds each voice's request until served, then presents its next address.
  initial begin
    ch_req  = '0;
    ch_addr = '0;
    forever begin
      @(negedge clk);
      for (int v = 0; v < NCH; v++) begin
        if (ch_valid[v] && vq[v].size() > 0) void'(vq[v].pop_front());
        if (vq[v].size() > 0) begin
          ch_req[v] = 1'b1;
          ch_addr[v*AW +: AW] = vq[v][0];
        end else begin
          ch_req[v] = 1'b0;
        end
      end
    end
  end

  // SDRAM model with random latency; can withhold acks or inject a stray one.
  initial begin
    int lat;
    mem_ack  = 1'b0;
    mem_dout = 16'hDEAD;
    forever begin
      @(negedge clk);
      if (stray_ack) begin
        mem_ack = 1'b1; mem_dout = 16'h1234;
        @(negedge clk);
        mem_ack = 1'b0; mem_dout = 16'hDEAD; stray_ack = 1'b0;
      end else if (!reset && mem_rd && !withhold) begin
        last_rd_addr = mem_addr;
        lat = int'($urandom_range(lat_max, lat_min));
        repeat (lat) @(negedge clk);
        mem_ack = 1'b1; mem_dout = memword(last_rd_addr);
        @(negedge clk);
        mem_ack = 1'b0; mem_dout = 16'hDEAD;
      end
    end
  end

  // Monitor: pops the scoreboard on every ch_valid and checks the read strobe shape.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (!reset) begin
        if (mem_rd) begin
          rd_cnt++;
          chk("rd_single_pulse", 32'(prev_rd), 32'd0);
          chk("rd_addr_aligned", 32'(mem_addr[0]), 32'd0);
        end
        if (dl_active) chk("rd_blocked_in_dl", 32'(mem_rd), 32'd0);
        if (ch_valid != '0) begin
          last_valid_cyc = cyc;
          valid_cnt++;
          if (expect_none) chk("spurious_valid", 32'(ch_valid), 32'd0);
          else if (expq.size() == 0) chk("unexpected_valid", 32'(ch_valid), 32'd0);
          else begin
            mon_e = expq.pop_front();
            chk("grant_voice", 32'(ch_valid), 32'd1 << mon_e.v);
            chk("read_data", 32'(ch_data), 32'(mon_e.d));
          end
        end
        prev_rd = mem_rd;
      end else begin
        prev_rd = 1'b0;
      end
    end
  end

  // Reference: serve pending voices in cyclic order after the last served voice.
  task automatic issue_batch(input bit to_mode);
    int rem[NCH];
    int used[NCH];
    int left, cur, nxt;
    logic [AW-1:0] a;
    exp_t e;
    @(posedge clk); #1;
    left = 0;
    for (int v = 0; v < NCH; v++) begin
      for (int j = 0; j < want[v]; j++) vq[v].push_back(use_force ? force_addr : AW'($urandom));
      rem[v] = want[v]; used[v] = 0; left += want[v];
    end
    cur = m_last;
    while (left > 0) begin
      nxt = -1;
      for (int k = NCH; k >= 1; k--) if (rem[(cur + k) % NCH] > 0) nxt = (cur + k) % NCH;
      a = vq[nxt][used[nxt]];
      e.v = nxt;
      e.d = to_mode ? 16'h0000 : memword({a[AW-1:1], 1'b0});
      expq.push_back(e);
      rem[nxt]--; used[nxt]++; left--;
      cur = nxt;
    end
    m_last = cur;
    @(negedge clk); #1;
    n0 = cyc;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    bit busy = 1'b1;
    while (busy && n < budget) begin
      @(negedge clk); #3;
      n++;
      busy = (expq.size() != 0);
      for (int v = 0; v < NCH; v++) if (vq[v].size() != 0) busy = 1'b1;
    end
    chk("drain_in_budget", 32'(expq.size()), 32'd0);
    expq.delete();
    for (int v = 0; v < NCH; v++) vq[v].delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_rd(input int start, input int budget);
    int n = 0;
    while (rd_cnt == start && n < budget) begin
      @(negedge clk); #3;
      n++;
    end
    chk("rd_issued", 32'(rd_cnt - start), 32'd1);
  endtask

  task automatic set_want(input int a, input int b, input int c, input int d);
    want[0] = a; want[1] = b; want[2] = c; want[3] = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_ch_valid"}, 32'(ch_valid), 32'd0);
    chk({tag, "_ch_data"}, 32'(ch_data), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

  initial begin
    int s, vc;
    reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    repeat (3) @(negedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single voice, odd byte address, fixed latency 3.
    lat_min = 3; lat_max = 3;
    use_force = 1'b1; force_addr = AW'(32'h00101);
    set_want(1, 0, 0, 0);
    s = rd_cnt;
    issue_batch(1'b0);
    wait_drain(100);
    use_force = 1'b0;
    chk("single_latency", 32'(last_valid_cyc - n0), 32'd5);
    chk("single_rd_count", 32'(rd_cnt - s), 32'd1);
    chk("single_mem_addr", 32'(last_rd_addr), 32'h100);

    // All voices requesting continuously for 8 transactions.
    lat_min = 1; lat_max = 4;
    set_want(2, 2, 2, 2);
    s = rd_cnt;
    issue_batch(1'b0);
    wait_drain(400);
    chk("fair_rd_count", 32'(rd_cnt - s), 32'd8);

    // Randomized voice mixes and latencies.
    lat_min = 1; lat_max = 5;
    for (int b = 0; b < 16; b++) begin
      for (int v = 0; v < NCH; v++) want[v] = int'($urandom_range(2, 0));
      if (want[0] + want[1] + want[2] + want[3] == 0) want[$urandom_range(3, 0)] = 1;
      issue_batch(1'b0);
      wait_drain(600);
    end

    // Stray ack while idle must not produce a response.
    vc = valid_cnt;
    expect_none = 1'b1; stray_ack = 1'b1;
    repeat (5) @(negedge clk);
    expect_none = 1'b0;
    chk("stray_ack_ignored", 32'(valid_cnt - vc), 32'd0);

    // Download takes the port mid-read; the voice is re-served afterwards.
    withhold = 1'b1;
    set_want(0, 1, 0, 0);
    s = rd_cnt;
    issue_batch(1'b0);
    wait_rd(s, 20);
    repeat (2) @(negedge clk);
    dl_active = 1'b1; expect_none = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dl_wr = 1'b1; dl_addr = AW'($urandom); dl_data = 8'($urandom);
      #1;
      chk("dl_mem_we", 32'(mem_we), 32'd1);
      chk("dl_mem_din", 32'(mem_din), 32'(dl_data));
      chk("dl_mem_addr", 32'(mem_addr), 32'(dl_addr));
      @(negedge clk);
      dl_wr = 1'b0;
      #1 chk("dl_mem_we_low", 32'(mem_we), 32'd0);
    end
    @(negedge clk);
    dl_active = 1'b0; expect_none = 1'b0; withhold = 1'b0;
    wait_drain(100);
    chk("dl_reissue_rd_count", 32'(rd_cnt - s), 32'd2);
    chk("no_timeout_yet", 32'(timeout_err), 32'd0);

    // Withheld ack: timeout returns zero data and sets the sticky flag.
    withhold = 1'b1;
    set_want(0, 0, 1, 0);
    issue_batch(1'b1);
    wait_drain(200);
    withhold = 1'b0;
    chk("timeout_latency", 32'(last_valid_cyc - n0), 32'(TO + 2));
    chk("timeout_err_set", 32'(timeout_err), 32'd1);
    set_want(1, 1, 0, 1);
    issue_batch(1'b0);
    wait_drain(200);
    chk("timeout_err_sticky", 32'(timeout_err), 32'd1);

    // Asynchronous reset while waiting for the memory.
    withhold = 1'b1;
    set_want(0, 0, 0, 1);
    s = rd_cnt;
    issue_batch(1'b0);
    wait_rd(s, 20);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_all_zero("async_reset");
    expq.delete();
    for (int v = 0; v < NCH; v++) vq[v].delete();
    m_last = NCH - 1;
    withhold = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    set_want(1, 0, 0, 1);
    issue_batch(1'b0);
    wait_drain(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sample_fetch_arb.md
# sample_fetch_arb

Read scheduler for the shared sample SDRAM port. It arbitrates word reads from up to NUM_CH sample-playback voices onto the single 16-bit SDRAM read channel. While a ROM or WAV download is active, it yields the port to download writes. It sits between the samples mixer and the sdram controller, in the clk_vid domain, and replaces direct wiring of one voice's read strobe to the memory.

## Interface
- NUM_CH, 4, number of requesting voices (2..8)
- ADDR_W, 25, byte address width
- TIMEOUT, 63, cycles to wait for mem_ack before abandoning a read (6-bit max)
- clk  in  1  clock (clk_vid)
- reset  in  1  asynchronous, active-high reset
- dl_active  in  1  download in progress; port owned by the download path
- dl_wr  in  1  download byte strobe
- dl_addr  in  ADDR_W  download byte address
- dl_data  in  8  download byte
- ch_req  in  NUM_CH  per-voice read request, level, held until ch_valid
- ch_addr  in  NUM_CH*ADDR_W  per-voice byte address; bit 0 is ignored (word aligned)
- ch_valid  out  NUM_CH  one-cycle data-valid pulse to the served voice
- ch_data  out  16  read word, qualified by ch_valid
- mem_addr  out  ADDR_W  SDRAM address
- mem_rd  out  1  one-cycle read strobe
- mem_we  out  1  write strobe (mirrors dl_wr while dl_active)
- mem_din  out  8  write byte
- mem_dout  in  16  SDRAM read data
- mem_ack  in  1  one-cycle read-complete pulse; mem_dout is valid in the same cycle
- timeout_err  out  1  sticky flag, set on any timeout, cleared only by reset

## Operation
- States: IDLE, ISSUE, WAIT, DONE. All state is held in a single FSM plus a round-robin pointer `last`.
- IDLE: if dl_active, stay. Otherwise, if any ch_req is set, select the first requester after `last` (cyclic), latch its index and word address {addr[ADDR_W-1:1],0}, and go to ISSUE.
- ISSUE: drive mem_rd=1 for exactly one cycle, update `last` to the granted index, then go to WAIT.
- WAIT: on mem_ack, capture mem_dout and go to DONE. If the timeout counter reaches TIMEOUT first, return data 16'h0000, set timeout_err, and go to DONE.
- DONE: pulse ch_valid[idx] with ch_data for one cycle, then go to IDLE.
- Download path: while dl_active, mem_we=dl_wr, mem_addr=dl_addr, mem_din=dl_data combinationally, and mem_rd is forced 0.
- If dl_active rises during ISSUE or WAIT, the FSM aborts to IDLE without a ch_valid. The voice keeps requesting and is re-served after dl_active falls.
- A requester dropping ch_req mid-transaction still receives its ch_valid pulse; the voice ignores it.
- Resets to 0: mem_rd, mem_we, ch_valid, ch_data, timeout_err, and `last` (set to NUM_CH-1, so voice 0 wins first). FSM resets to IDLE. mem_addr resets to 0.

## Timing
- Request sampled in IDLE at cycle n → mem_rd at n+1 → mem_ack at n+1+L → ch_valid at n+2+L. Minimum L=1, giving 4-cycle turnaround.
- One outstanding read at a time. Back-to-back service gives a new grant in IDLE the cycle after DONE.
- Fairness: with all voices requesting continuously, each voice is served exactly once per NUM_CH transactions.
- The timeout counter is 6 bits, cleared on entering WAIT, and saturates without wrapping.
- mem_ack outside WAIT is ignored.

## Configuration
- SAMPLE_FETCH_CACHE_EN defined: each voice gets a one-word cache (tag = word address, plus a valid bit).
  - In IDLE, the highest-priority requester that hits is answered directly in DONE, with no SDRAM access (2-cycle turnaround).
  - Misses fill the cache on mem_ack.
  - A timeout fill does not set the valid bit.
  - Any download write, and reset, invalidates all cache entries.
- SAMPLE_FETCH_CACHE_EN undefined: no cache storage; every request goes to SDRAM.

## Structure
- sample_fetch_pkg holds the FSM state enum, the default NUM_CH/ADDR_W/TIMEOUT constants, and the word-align helper function.
- Sub-module rr_arbiter (NUM_CH): takes a request vector and the `last` pointer, and returns a one-hot grant plus an index. It is purely combinational and reused by the cache-hit path.

## Test plan
- Single voice: ch_req[0] with addr 0x00101 and an SDRAM model at L=3 returning 0xBEEF → mem_addr=0x00100, mem_rd is one pulse, ch_valid[0] at request+5, ch_data=0xBEEF.
- All 4 voices requesting continuously for 8 transactions → grant order 0,1,2,3,0,1,2,3; no voice is served twice in a row.
- dl_active asserted during WAIT → no ch_valid; 3 dl_wr bytes pass to mem_we/mem_din unchanged; after dl_active falls the same voice is re-issued.
- Model withholds mem_ack → after 63 WAIT cycles, ch_valid with ch_data=0x0000 and timeout_err=1, held until reset.
- Reset asserted in WAIT → all outputs 0 immediately (async); a subsequent request from voice 0 is served first.
- With SAMPLE_FETCH_CACHE_EN: voice 1 reads 0x200 twice → second read has no mem_rd, ch_valid 2 cycles after request; after one dl_wr the next read of 0x200 issues mem_rd again.
